// File: rtl/ysyx_23060236_arbiter.sv
// ============================================================================
// ysyx_23060236_arbiter
// ----------------------------------------------------------------------------
// Purpose
//   Shares one AXI4-Lite-style downstream master port between two upstream
//   masters: the LSU (read and write channels) and the IFU (read channel
//   only). One whole transaction is granted at a time. Requests are sampled
//   only in IDLE, using fixed priority: LSU write, then LSU read, then IFU
//   read. While a master is granted, its channels are wired straight through
//   to the downstream port. The other master sees every ready/valid at 0,
//   so its request stalls until the next IDLE cycle.
//
// Ports
//   clock, reset          sole clock; synchronous active-high reset
//   ifu_ar*/ifu_r*        IFU read address / read data channels
//   lsu_ar*/lsu_r*        LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b* LSU write address / write data / write response
//   out_*                 downstream port toward memory / xbar
//   state_o               debug view of the grant FSM
//                         (0 IDLE, 1 IFU_RD, 2 LSU_RD, 3 LSU_WR)
//
// Handshake semantics
//   A transfer on any channel happens on the rising clock edge where both
//   valid and ready are high. A source holds valid, and keeps its payload
//   stable, until that edge. Ready may rise or fall freely. The arbiter never
//   creates or drops a transfer; it only gates which master's valid/ready
//   pair is connected to the downstream port.
// ============================================================================
module ysyx_23060236_arbiter (
    input  logic        clock,
    input  logic        reset,

    // IFU read address channel
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    // IFU read data channel
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    // LSU read address channel
    input  logic [31:0] lsu_araddr,
    input  logic [2:0]  lsu_arsize,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    // LSU read data channel
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    // LSU write address channel
    input  logic [31:0] lsu_awaddr,
    input  logic [2:0]  lsu_awsize,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    // LSU write data channel
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    // LSU write response channel
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,

    // Downstream read address channel
    output logic [31:0] out_araddr,
    output logic [2:0]  out_arsize,
    output logic        out_arvalid,
    input  logic        out_arready,
    // Downstream read data channel
    input  logic [31:0] out_rdata,
    input  logic [1:0]  out_rresp,
    input  logic        out_rvalid,
    output logic        out_rready,
    // Downstream write address channel
    output logic [31:0] out_awaddr,
    output logic [2:0]  out_awsize,
    output logic        out_awvalid,
    input  logic        out_awready,
    // Downstream write data channel
    output logic [31:0] out_wdata,
    output logic [3:0]  out_wstrb,
    output logic        out_wvalid,
    input  logic        out_wready,
    // Downstream write response channel
    input  logic [1:0]  out_bresp,
    input  logic        out_bvalid,
    output logic        out_bready,

    // Debug: current grant state
    output logic [1:0]  state_o
);

    // ------------------------------------------------------------------------
    // Grant states
    // ------------------------------------------------------------------------
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IFU_RD = 2'd1;
    localparam logic [1:0] LSU_RD = 2'd2;
    localparam logic [1:0] LSU_WR = 2'd3;

    // The IFU always fetches full 32-bit words.
    localparam logic [2:0] IFU_SIZE = 3'b010;

    logic [1:0] state_q;
    logic [1:0] state_d;

    // Completion events of the granted transaction. Each one is the final
    // handshake, so the cycle in which it fires is the last granted cycle.
    logic r_done;
    logic b_done;

    assign r_done = out_rvalid & out_rready;
    assign b_done = out_bvalid & out_bready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A write may present W before AW, so either one starts it.
                if (lsu_awvalid | lsu_wvalid) begin
                    state_d = LSU_WR;
                end else if (lsu_arvalid) begin
                    state_d = LSU_RD;
                end else if (ifu_arvalid) begin
                    state_d = IFU_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            IFU_RD, LSU_RD: begin
                if (r_done) begin
                    state_d = IDLE;
                end
            end
            LSU_WR: begin
                // AW and W may complete in any order and on any cycles.
                // Only B closes the write.
                if (b_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register: the only storage in the block
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

    // ------------------------------------------------------------------------
    // Channel routing
    //
    // Every output defaults to 0. This single default covers three cases:
    //   - IDLE drives all valids, readies and payloads low;
    //   - the non-granted master sees zero ready/valid;
    //   - the channels of the granted master that are unused in this
    //     transaction stay low.
    // ------------------------------------------------------------------------
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = 32'd0;
        ifu_rresp   = 2'b00;
        ifu_rvalid  = 1'b0;

        lsu_arready = 1'b0;
        lsu_rdata   = 32'd0;
        lsu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'b00;
        lsu_bvalid  = 1'b0;

        out_araddr  = 32'd0;
        out_arsize  = 3'b000;
        out_arvalid = 1'b0;
        out_rready  = 1'b0;
        out_awaddr  = 32'd0;
        out_awsize  = 3'b000;
        out_awvalid = 1'b0;
        out_wdata   = 32'd0;
        out_wstrb   = 4'h0;
        out_wvalid  = 1'b0;
        out_bready  = 1'b0;

        case (state_q)
            IFU_RD: begin
                out_araddr  = ifu_araddr;
                out_arsize  = IFU_SIZE;
                out_arvalid = ifu_arvalid;
                ifu_arready = out_arready;

                ifu_rdata   = out_rdata;
                ifu_rresp   = out_rresp;
                ifu_rvalid  = out_rvalid;
                out_rready  = ifu_rready;
            end
            LSU_RD: begin
                out_araddr  = lsu_araddr;
                out_arsize  = lsu_arsize;
                out_arvalid = lsu_arvalid;
                lsu_arready = out_arready;

                lsu_rdata   = out_rdata;
                lsu_rresp   = out_rresp;
                lsu_rvalid  = out_rvalid;
                out_rready  = lsu_rready;
            end
            LSU_WR: begin
                // AW and W are forwarded independently; the slave may
                // accept them in either order.
                out_awaddr  = lsu_awaddr;
                out_awsize  = lsu_awsize;
                out_awvalid = lsu_awvalid;
                lsu_awready = out_awready;

                out_wdata   = lsu_wdata;
                out_wstrb   = lsu_wstrb;
                out_wvalid  = lsu_wvalid;
                lsu_wready  = out_wready;

                lsu_bresp   = out_bresp;
                lsu_bvalid  = out_bvalid;
                out_bready  = lsu_bready;
            end
            default: begin
                // IDLE: everything stays at its zero default.
            end
        endcase
    end

endmodule
